voice_param_scheduler: RTL and testbench
========================================

Name: voice_param_scheduler

Overview:
- Sits between the SPI note decoder and the synth voice engine.
- Queues decoded note-on/note-off events in a small FIFO and applies them to an internal per-voice parameter register file (gate, tuning code, velocity).
- Arbitrates the file's single access slot between event writes and the synth engine's per-voice scan reads.
- Scan reads have priority; a stall counter bounds how long a pending write can wait.

Parameters:
- NUM_VOICES, 16, number of voice slots in the register file.
- VOICE_AW, 4, voice address width; must satisfy 2**VOICE_AW >= NUM_VOICES.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- MAX_STALL, 8, maximum consecutive cycles a non-empty FIFO may be denied the slot.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_reset_n  in  1  reset; asynchronous assert, active-low.
- i_SPI_flag  in  1  one-cycle strobe; the event fields below are valid in that cycle.
- i_SPI_note_status  in  1  1 = note-on, 0 = note-off.
- i_SPI_voice_index  in  8  target voice.
- i_SPI_tuning_code  in  32  phase increment (used on note-on only).
- i_SPI_velocity  in  7  velocity (used on note-on only).
- i_scan_req  in  1  synth engine requests a read.
- i_scan_addr  in  VOICE_AW  voice to read.
- o_scan_ready  out  1  read slot available this cycle.
- o_scan_valid  out  1  read data valid.
- o_scan_gate  out  1  gate of the read voice.
- o_scan_tuning_code  out  32  tuning code of the read voice.
- o_scan_velocity  out  7  velocity of the read voice.
- o_fifo_overflow  out  1  sticky; an event was lost because the FIFO was full.
- o_drop_count  out  8  saturating count of events rejected for an out-of-range voice index.

Behaviour:
Reset (async, i_reset_n=0):
- All gates, tuning codes and velocities are cleared to 0.
- FIFO is emptied and the stall counter is set to 0.
- o_scan_valid=0, all scan data outputs 0, o_fifo_overflow=0, o_drop_count=0.
- Reset asserted mid-transaction aborts it; no partial write survives.

Event capture (cycle i_SPI_flag=1):
- If i_SPI_voice_index >= NUM_VOICES: event is discarded and o_drop_count increments, saturating at 255.
- Else, if the FIFO is not full, or a pop occurs in the same cycle: the tuple {status, index[VOICE_AW-1:0], tuning, velocity} is pushed.
- Else: event is discarded and o_fifo_overflow is set. It stays set until reset.

Arbitration (one register-file access per cycle):
- force_wr = FIFO non-empty AND stall_cnt == MAX_STALL.
- o_scan_ready = !force_wr. It is combinational from registered state only, with no dependence on i_scan_req.
- Read grant: i_scan_req && o_scan_ready.
  - The addressed entry is registered to the o_scan_* data outputs.
  - o_scan_valid=1 in the next cycle (latency 1).
  - Back-to-back reads are allowed, one per cycle.
  - If i_scan_addr >= NUM_VOICES: o_scan_valid still pulses and the data is all 0.
- Write: occurs in any cycle where the FIFO is non-empty and no read grant is given.
  - Pops the FIFO head and stall_cnt <- 0.
  - Note-on: gate=1, tuning and velocity are overwritten.
  - Note-off: gate=0; tuning and velocity are retained for release.
- Stall counter:
  - FIFO non-empty and read granted: stall_cnt increments, saturating at MAX_STALL.
  - FIFO empty: stall_cnt <- 0.
- A write takes effect at the clock edge. A read of the same voice in a later cycle returns the new value; there is no same-cycle read/write conflict because only one access occurs per cycle.

Ordering:
- Events are applied in arrival order.
- Two events to the same voice are applied in sequence; the last one wins.

Optional Feature:
- Macro VOICE_PARAM_ACTIVE_MASK_EN.
- Defined: adds output o_active_mask [NUM_VOICES-1:0], where bit v = gate of voice v.
  - Registered; it updates in the same edge as the write.
  - Reset value is 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then note-on {idx 3, tuning 0x00123456, vel 100} with i_scan_req=0 → written next cycle; scan of addr 3 returns gate=1, tuning 0x00123456, vel 100, with o_scan_valid one cycle after grant.
- Note-on idx 5, then note-off idx 5 → scan returns gate=0, tuning and vel unchanged.
- i_scan_req held high continuously while one event is pending → o_scan_ready drops for exactly one cycle after 8 granted reads; the event is written in that cycle and o_scan_ready returns to 1.
- Push 5 events in consecutive flag cycles with i_scan_req=1 → 4 are queued and the 5th sets o_fifo_overflow=1. The queued 4 are applied in order; the overflow flag stays 1 until reset.
- Note-on with voice index 20 → o_drop_count=1, no register change, scan of all voices shows gate=0.
- Assert i_reset_n=0 while the FIFO holds 3 events → after release, all scans return zeros and o_scan_valid=0 until the first new grant; with VOICE_PARAM_ACTIVE_MASK_EN defined, o_active_mask=0.

Source files
------------

// File: rtl/voice_param_scheduler.sv
// voice_param_scheduler
// Queues note-on/note-off events from the SPI decoder in a small FIFO and
// applies them to a per-voice parameter file (gate, tuning code, velocity).
// The file has one access slot per cycle. Scan reads from the synth engine
// take priority. A stall counter forces a write through once a pending
// event has been held off for MAX_STALL granted reads.
// Optional build macro: VOICE_PARAM_ACTIVE_MASK_EN adds o_active_mask,
// a registered copy of every voice's gate bit.

module voice_param_scheduler #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_AW   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STALL  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_SPI_flag,
    input  logic                i_SPI_note_status,
    input  logic [7:0]          i_SPI_voice_index,
    input  logic [31:0]         i_SPI_tuning_code,
    input  logic [6:0]          i_SPI_velocity,
    input  logic                i_scan_req,
    input  logic [VOICE_AW-1:0] i_scan_addr,
    output logic                o_scan_ready,
    output logic                o_scan_valid,
    output logic                o_scan_gate,
    output logic [31:0]         o_scan_tuning_code,
    output logic [6:0]          o_scan_velocity,
    output logic                o_fifo_overflow,
    output logic [7:0]          o_drop_count
`ifdef VOICE_PARAM_ACTIVE_MASK_EN
    ,
    output logic [NUM_VOICES-1:0] o_active_mask
`endif
);

    localparam int LP_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LP_CW = LP_PW + 1;
    localparam int LP_SW = $clog2(MAX_STALL + 1);

    localparam logic [LP_CW-1:0] LP_DEPTH     = LP_CW'(FIFO_DEPTH);
    localparam logic [LP_CW-1:0] LP_CNT_ONE   = LP_CW'(1);
    localparam logic [LP_PW-1:0] LP_PTR_ONE   = LP_PW'(1);
    localparam logic [LP_SW-1:0] LP_MAX_STALL = LP_SW'(MAX_STALL);
    localparam logic [LP_SW-1:0] LP_STALL_ONE = LP_SW'(1);
    localparam logic [31:0]      LP_NV        = 32'(NUM_VOICES);

    // Event FIFO storage, split per field
    logic                r_fifo_on   [FIFO_DEPTH];
    logic [VOICE_AW-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic [31:0]         r_fifo_tune [FIFO_DEPTH];
    logic [6:0]          r_fifo_vel  [FIFO_DEPTH];

    logic [LP_PW-1:0]    r_wr_ptr;
    logic [LP_PW-1:0]    r_rd_ptr;
    logic [LP_CW-1:0]    r_count;
    logic [LP_SW-1:0]    r_stall_cnt;

    // Per-voice parameter file
    logic                r_gate [NUM_VOICES];
    logic [31:0]         r_tune [NUM_VOICES];
    logic [6:0]          r_vel  [NUM_VOICES];

    logic                r_scan_valid;
    logic                r_scan_gate;
    logic [31:0]         r_scan_tune;
    logic [6:0]          r_scan_vel;
    logic                r_overflow;
    logic [7:0]          r_drop_count;

    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic                w_force_wr;
    logic                w_scan_ready;
    logic                w_rd_grant;
    logic                w_wr_en;
    logic                w_idx_ok;
    logic                w_push;
    logic                w_lost;
    logic                w_scan_in_range;
    logic                w_head_on;
    logic [VOICE_AW-1:0] w_head_idx;
    logic [31:0]         w_head_tune;
    logic [6:0]          w_head_vel;

    assign w_fifo_empty    = (r_count == '0);
    assign w_fifo_full     = (r_count == LP_DEPTH);

    // The scan slot is withheld only when a queued event has waited its limit.
    assign w_force_wr      = !w_fifo_empty && (r_stall_cnt == LP_MAX_STALL);
    assign w_scan_ready    = !w_force_wr;
    assign w_rd_grant      = i_scan_req && w_scan_ready;
    assign w_wr_en         = !w_fifo_empty && !w_rd_grant;

    assign w_idx_ok        = (32'(i_SPI_voice_index) < LP_NV);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push          = i_SPI_flag && w_idx_ok && (!w_fifo_full || w_wr_en);
    assign w_lost          = i_SPI_flag && w_idx_ok && w_fifo_full && !w_wr_en;
    assign w_scan_in_range = (32'(i_scan_addr) < LP_NV);

    assign w_head_on       = r_fifo_on[r_rd_ptr];
    assign w_head_idx      = r_fifo_idx[r_rd_ptr];
    assign w_head_tune     = r_fifo_tune[r_rd_ptr];
    assign w_head_vel      = r_fifo_vel[r_rd_ptr];

    // FIFO payload write; contents are don't-care while the slot is empty
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_on[r_wr_ptr]   <= i_SPI_note_status;
            r_fifo_idx[r_wr_ptr]  <= i_SPI_voice_index[VOICE_AW-1:0];
            r_fifo_tune[r_wr_ptr] <= i_SPI_tuning_code;
            r_fifo_vel[r_wr_ptr]  <= i_SPI_velocity;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_wr_en) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_wr_en})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stall counter: counts reads granted over a waiting event
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_fifo_empty || w_wr_en) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != LP_MAX_STALL) begin
            r_stall_cnt <= r_stall_cnt + LP_STALL_ONE;
        end
    end

    // Parameter file update from the FIFO head; note-off keeps tuning/velocity
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_gate[v] <= 1'b0;
                r_tune[v] <= '0;
                r_vel[v]  <= '0;
            end
        end else if (w_wr_en) begin
            if (w_head_on) begin
                r_gate[w_head_idx] <= 1'b1;
                r_tune[w_head_idx] <= w_head_tune;
                r_vel[w_head_idx]  <= w_head_vel;
            end else begin
                r_gate[w_head_idx] <= 1'b0;
            end
        end
    end

    // Scan read port: one-cycle latency, zero data for unmapped addresses
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_scan_valid <= 1'b0;
            r_scan_gate  <= 1'b0;
            r_scan_tune  <= '0;
            r_scan_vel   <= '0;
        end else begin
            r_scan_valid <= w_rd_grant;
            if (w_rd_grant) begin
                if (w_scan_in_range) begin
                    r_scan_gate <= r_gate[i_scan_addr];
                    r_scan_tune <= r_tune[i_scan_addr];
                    r_scan_vel  <= r_vel[i_scan_addr];
                end else begin
                    r_scan_gate <= 1'b0;
                    r_scan_tune <= '0;
                    r_scan_vel  <= '0;
                end
            end
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
            if (i_SPI_flag && !w_idx_ok && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

`ifdef VOICE_PARAM_ACTIVE_MASK_EN
    logic [NUM_VOICES-1:0] r_active_mask;

    // Gate mirror, updated on the same edge as the parameter file write
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_active_mask <= '0;
        end else if (w_wr_en) begin
            r_active_mask[w_head_idx] <= w_head_on;
        end
    end

    assign o_active_mask = r_active_mask;
`endif

    assign o_scan_ready       = w_scan_ready;
    assign o_scan_valid       = r_scan_valid;
    assign o_scan_gate        = r_scan_gate;
    assign o_scan_tuning_code = r_scan_tune;
    assign o_scan_velocity    = r_scan_vel;
    assign o_fifo_overflow    = r_overflow;
    assign o_drop_count       = r_drop_count;

endmodule

// File: tb/tb_voice_param_scheduler.sv
// Randomized and directed bench for voice_param_scheduler with a
// transaction-level reference model (event queue + per-voice arrays).
// Build with VOICE_PARAM_ACTIVE_MASK_EN defined to also check o_active_mask.

module tb_voice_param_scheduler;

    localparam int NV    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int MS    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          spi_flag;
    logic          spi_on;
    logic [7:0]    spi_idx;
    logic [31:0]   spi_tune;
    logic [6:0]    spi_vel;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_ready;
    logic          scan_valid;
    logic          scan_gate;
    logic [31:0]   scan_tune;
    logic [6:0]    scan_vel;
    logic          fifo_ovf;
    logic [7:0]    drop_cnt;
`ifdef VOICE_PARAM_ACTIVE_MASK_EN
    logic [NV-1:0] active_mask;
`endif

    always #5 clk = ~clk;

    voice_param_scheduler #(
        .NUM_VOICES (NV),
        .VOICE_AW   (AW),
        .FIFO_DEPTH (DEPTH),
        .MAX_STALL  (MS)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_SPI_flag         (spi_flag),
        .i_SPI_note_status  (spi_on),
        .i_SPI_voice_index  (spi_idx),
        .i_SPI_tuning_code  (spi_tune),
        .i_SPI_velocity     (spi_vel),
        .i_scan_req         (scan_req),
        .i_scan_addr        (scan_addr),
        .o_scan_ready       (scan_ready),
        .o_scan_valid       (scan_valid),
        .o_scan_gate        (scan_gate),
        .o_scan_tuning_code (scan_tune),
        .o_scan_velocity    (scan_vel),
        .o_fifo_overflow    (fifo_ovf),
        .o_drop_count       (drop_cnt)
`ifdef VOICE_PARAM_ACTIVE_MASK_EN
        ,
        .o_active_mask      (active_mask)
`endif
    );

    typedef struct {
        bit          on;
        int          idx;
        logic [31:0] tune;
        logic [6:0]  vel;
    } ev_t;

    // Reference model state
    ev_t         m_q[$];
    bit          m_gate[NV];
    logic [31:0] m_tune[NV];
    logic [6:0]  m_vel[NV];
    int          m_waited;
    bit          m_ovf;
    int          m_drop;
    bit          e_valid;
    bit          e_gate;
    logic [31:0] e_tune;
    logic [6:0]  e_vel;
    bit          last_ready;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int v = 0; v < NV; v++) begin
            m_gate[v] = 1'b0;
            m_tune[v] = '0;
            m_vel[v]  = '0;
        end
        m_waited = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        e_valid  = 1'b0;
    endtask

    function automatic logic [NV-1:0] model_mask();
        logic [NV-1:0] m;
        m = '0;
        for (int v = 0; v < NV; v++) m[v] = m_gate[v];
        return m;
    endfunction

    task automatic check_reset_state();
        check("rst_valid", scan_valid, 1'b0);
        check("rst_gate", scan_gate, 1'b0);
        check("rst_tune", scan_tune, 32'h0);
        check("rst_vel", scan_vel, 7'h0);
        check("rst_ovf", fifo_ovf, 1'b0);
        check("rst_drop", drop_cnt, 8'h0);
`ifdef VOICE_PARAM_ACTIVE_MASK_EN
        check("rst_mask", active_mask, '0);
`endif
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", scan_ready, 1'b1);
    endtask

    // One clock of stimulus; the model advances by the behavioural rules
    task automatic cycle(input bit f, input bit on, input int idx, input logic [31:0] tu,
                         input logic [6:0] ve, input bit req, input int addr);
        bit  rdy;
        bit  grant;
        bit  popped;
        int  size_before;
        ev_t ev;
        @(negedge clk);
        spi_flag  = f;
        spi_on    = on;
        spi_idx   = 8'(idx);
        spi_tune  = tu;
        spi_vel   = ve;
        scan_req  = req;
        scan_addr = AW'(addr);
        #1;
        size_before = m_q.size();
        rdy = !(size_before > 0 && m_waited >= MS);
        last_ready = scan_ready;
        check("scan_ready", scan_ready, rdy);
        grant  = req && rdy;
        popped = 1'b0;
        e_valid = grant;
        if (grant) begin
            e_gate = (addr < NV) ? m_gate[addr] : 1'b0;
            e_tune = (addr < NV) ? m_tune[addr] : 32'h0;
            e_vel  = (addr < NV) ? m_vel[addr]  : 7'h0;
            if (size_before > 0 && m_waited < MS) m_waited++;
        end else if (size_before > 0) begin
            ev = m_q.pop_front();
            m_gate[ev.idx] = ev.on;
            if (ev.on) begin
                m_tune[ev.idx] = ev.tune;
                m_vel[ev.idx]  = ev.vel;
            end
            popped = 1'b1;
            m_waited = 0;
        end
        if (size_before == 0) m_waited = 0;
        if (f) begin
            if (idx >= NV) begin
                if (m_drop < 255) m_drop++;
            end else if (size_before < DEPTH || popped) begin
                ev.on = on; ev.idx = idx; ev.tune = tu; ev.vel = ve;
                m_q.push_back(ev);
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("scan_valid", scan_valid, e_valid);
        if (e_valid) begin
            check("scan_gate", scan_gate, e_gate);
            check("scan_tune", scan_tune, e_tune);
            check("scan_vel", scan_vel, e_vel);
        end
        check("fifo_overflow", fifo_ovf, m_ovf);
        check("drop_count", drop_cnt, 8'(m_drop));
`ifdef VOICE_PARAM_ACTIVE_MASK_EN
        check("active_mask", active_mask, model_mask());
`endif
        spi_flag = 1'b0;
        scan_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic scan(input int addr);
        cycle(0, 0, 0, 0, 0, 1, addr);
    endtask

    initial begin
        int lows;
        int highs_before;
        bit seen_low;
        rst_n     = 1'b0;
        spi_flag  = 1'b0;
        spi_on    = 1'b0;
        spi_idx   = '0;
        spi_tune  = '0;
        spi_vel   = '0;
        scan_req  = 1'b0;
        scan_addr = '0;
        model_reset();
        #12;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        // Note-on to voice 3, then read it back
        cycle(1, 1, 3, 32'h0012_3456, 7'd100, 0, 0);
        idle(1);
        scan(3);
        check("dir_v3_gate", scan_gate, 1'b1);
        check("dir_v3_tune", scan_tune, 32'h0012_3456);
        check("dir_v3_vel", scan_vel, 7'd100);

        // Note-on then note-off on voice 5 keeps tuning and velocity
        cycle(1, 1, 5, 32'hCAFE_0005, 7'd55, 0, 0);
        cycle(1, 0, 5, 32'hFFFF_FFFF, 7'd1, 0, 0);
        idle(1);
        scan(5);
        check("dir_v5_gate", scan_gate, 1'b0);
        check("dir_v5_tune", scan_tune, 32'hCAFE_0005);
        check("dir_v5_vel", scan_vel, 7'd55);

        // Continuous scan with one pending event: exactly one forced write
        cycle(1, 1, 9, 32'h0000_0909, 7'd9, 1, 0);
        lows = 0;
        highs_before = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle(0, 0, 0, 0, 0, 1, i % NV);
            if (!last_ready) begin
                lows++;
                seen_low = 1'b1;
            end else if (!seen_low) begin
                highs_before++;
            end
        end
        check("force_low_cycles", 64'(lows), 64'd1);
        check("grants_before_force", 64'(highs_before), 64'(MS));
        scan(9);
        check("dir_v9_gate", scan_gate, 1'b1);

        // Five back-to-back events under scan pressure: fifth overflows
        for (int i = 0; i < 5; i++) cycle(1, 1, 10 + (i % 2), 32'h100 + 32'(i), 7'(i + 1), 1, 0);
        check("ovf_set", fifo_ovf, 1'b1);
        idle(6);
        scan(10);
        check("ovf_v10_tune", scan_tune, 32'h102);
        scan(11);
        check("ovf_v11_tune", scan_tune, 32'h103);
        check("ovf_sticky", fifo_ovf, 1'b1);

        // Out-of-range voice index is dropped
        apply_reset();
        cycle(1, 1, 20, 32'h1234, 7'd3, 0, 0);
        check("drop_one", drop_cnt, 8'd1);
        idle(2);
        for (int v = 0; v < NV; v++) scan(v);

        // Reset while the FIFO holds three events
        for (int i = 0; i < 3; i++) cycle(1, 1, i, 32'hABC0 + 32'(i), 7'd7, 1, 0);
        apply_reset();
        idle(2);
        check("post_rst_valid", scan_valid, 1'b0);
        for (int v = 0; v < NV; v++) scan(v);

        // Random traffic, with one reset part way through
        for (int n = 0; n < 3000; n++) begin
            int idx;
            if (n == 1500) apply_reset();
            idx = ($urandom_range(0, 9) == 0) ? $urandom_range(NV, 255) : $urandom_range(0, NV - 1);
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, idx, $urandom(),
                  7'($urandom_range(0, 127)), $urandom_range(0, 3) != 0, $urandom_range(0, NV - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
